// File: rtl/syn_acortex_reg_map.sv
// Audio cortex local-bus register map: I2C master register addresses.
package syn_acortex_reg_map;

    localparam logic [7:0] ACORTEX_I2CM_ADDR_REG_ADDR   = 8'h20;
    localparam logic [7:0] ACORTEX_I2CM_DATA_REG_ADDR   = 8'h21;
    localparam logic [7:0] ACORTEX_I2CM_STATUS_REG_ADDR = 8'h22;

endpackage

// File: rtl/syn_global_pkg.sv
// Shared types and constants: WM8731 register indices, config word layout,
// default configuration table and the config sequencer state encoding.
package syn_global_pkg;

    localparam logic [6:0] WM8731_R0_LLINE_IN   = 7'd0;
    localparam logic [6:0] WM8731_R1_RLINE_IN   = 7'd1;
    localparam logic [6:0] WM8731_R2_LHP_OUT    = 7'd2;
    localparam logic [6:0] WM8731_R3_RHP_OUT    = 7'd3;
    localparam logic [6:0] WM8731_R4_ANA_PATH   = 7'd4;
    localparam logic [6:0] WM8731_R5_DIG_PATH   = 7'd5;
    localparam logic [6:0] WM8731_R6_PWR_DOWN   = 7'd6;
    localparam logic [6:0] WM8731_R7_DIG_IF     = 7'd7;
    localparam logic [6:0] WM8731_R8_SAMPLING   = 7'd8;
    localparam logic [6:0] WM8731_R9_ACTIVE     = 7'd9;
    localparam logic [6:0] WM8731_R15_RESET     = 7'd15;

    typedef struct packed {
        logic [6:0] reg_num;
        logic [8:0] val;
    } wm8731_cfg_word_t;

    localparam int WM8731_CFG_LEN = 11;

    // Reset first, then bring up paths, activate last.
    localparam wm8731_cfg_word_t WM8731_CFG_TABLE [WM8731_CFG_LEN] = '{
        '{WM8731_R15_RESET,   9'h000},
        '{WM8731_R0_LLINE_IN, 9'h017},
        '{WM8731_R1_RLINE_IN, 9'h017},
        '{WM8731_R2_LHP_OUT,  9'h079},
        '{WM8731_R3_RHP_OUT,  9'h079},
        '{WM8731_R4_ANA_PATH, 9'h012},
        '{WM8731_R5_DIG_PATH, 9'h000},
        '{WM8731_R6_PWR_DOWN, 9'h000},
        '{WM8731_R7_DIG_IF,   9'h042},
        '{WM8731_R8_SAMPLING, 9'h000},
        '{WM8731_R9_ACTIVE,   9'h001}
    };

    typedef enum logic [3:0] {
        IDLE_S,
        WR_ADDR_S,
        WR_DATA_S,
        TRIG_S,
        GAP_S,
        POLL_S,
        NEXT_S,
        DONE_S,
        ERR_S
    } cfg_state_t;

endpackage

// File: rtl/syn_wm8731_cfg_rom.sv
// Combinational lookup of the WM8731 configuration table; entries past
// P_NUM_CMDS read as zero.
module syn_wm8731_cfg_rom
    import syn_global_pkg::*;
#(
    parameter int P_NUM_CMDS = 11
) (
    input  logic [3:0]       idx,
    output wm8731_cfg_word_t word
);

    always_comb begin
        word = '0;
        if (int'(idx) < P_NUM_CMDS && int'(idx) < WM8731_CFG_LEN) begin
            word = WM8731_CFG_TABLE[idx];
        end
    end

endmodule

// File: rtl/syn_wm8731_cfg_seq.sv
// WM8731 configuration sequencer: walks the codec register table through the
// I2C master's local bus. Optional NACK retry: SYN_WM8731_CFG_RETRY_EN.
//
// state     | meaning
// IDLE_S    | waiting for cfg_start
// WR_ADDR_S | write device address to I2CM address register
// WR_DATA_S | write table[idx] to I2CM data register
// TRIG_S    | write status register to launch the transaction
// GAP_S     | idle P_POLL_GAP clocks before polling
// POLL_S    | read status: busy -> GAP_S, NACK -> retry/ERR_S, ok -> NEXT_S
// NEXT_S    | advance index or finish
// DONE_S    | cfg_done high for one cycle
// ERR_S     | latch error and index
module syn_wm8731_cfg_seq
    import syn_global_pkg::*;
    import syn_acortex_reg_map::*;
#(
    parameter int         P_LB_DATA_W    = 16,
    parameter int         P_LB_ADDR_W    = 8,
    parameter logic [7:0] P_I2C_DEV_ADDR = 8'h34,
    parameter int         P_NUM_CMDS     = 11,
    parameter int         P_POLL_GAP     = 16,
    parameter int         P_MAX_POLLS    = 1023,
    parameter int         P_MAX_RETRY    = 3
) (
    input  logic                   clk_ir,
    input  logic                   rst_sync_l,
    input  logic                   cfg_start,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic [3:0]             cfg_err_idx,
`ifdef SYN_WM8731_CFG_RETRY_EN
    output logic [1:0]             cfg_retry_cnt,
`endif
    output logic                   i2cm_wr_en,
    output logic                   i2cm_rd_en,
    output logic [P_LB_ADDR_W-1:0] i2cm_addr,
    output logic [P_LB_DATA_W-1:0] i2cm_wr_data,
    input  logic                   i2cm_wr_valid,
    input  logic                   i2cm_rd_valid,
    input  logic [P_LB_DATA_W-1:0] i2cm_rd_data
);

    localparam int GAP_W  = 16;
    localparam int POLL_W = 10;

    cfg_state_t              state, state_nxt;
    logic [3:0]              idx, idx_nxt;
    logic [POLL_W-1:0]       poll_cnt, poll_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic                    issued, issued_nxt;
    logic                    wr_en_nxt, rd_en_nxt, done_nxt, err_nxt;
    logic [P_LB_ADDR_W-1:0]  addr_nxt;
    logic [P_LB_DATA_W-1:0]  wdata_nxt;
    logic [3:0]              err_idx_nxt;
    wm8731_cfg_word_t        rom_word;
    logic [15:0]             rom_bits;
    logic                    unused_rd;
`ifdef SYN_WM8731_CFG_RETRY_EN
    logic [1:0]              retry_cnt, retry_nxt;
    assign cfg_retry_cnt = retry_cnt;
`endif

    assign unused_rd = ^i2cm_rd_data[P_LB_DATA_W-1:2];
    assign rom_bits  = rom_word;

    syn_wm8731_cfg_rom #(.P_NUM_CMDS(P_NUM_CMDS)) u_rom (
        .idx  (idx),
        .word (rom_word)
    );

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state        <= IDLE_S;
            idx          <= '0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
            issued       <= 1'b0;
            i2cm_wr_en   <= 1'b0;
            i2cm_rd_en   <= 1'b0;
            i2cm_addr    <= '0;
            i2cm_wr_data <= '0;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            cfg_err_idx  <= '0;
`ifdef SYN_WM8731_CFG_RETRY_EN
            retry_cnt    <= '0;
`endif
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            poll_cnt     <= poll_nxt;
            gap_cnt      <= gap_nxt;
            issued       <= issued_nxt;
            i2cm_wr_en   <= wr_en_nxt;
            i2cm_rd_en   <= rd_en_nxt;
            i2cm_addr    <= addr_nxt;
            i2cm_wr_data <= wdata_nxt;
            cfg_busy     <= (state_nxt != IDLE_S);
            cfg_done     <= done_nxt;
            cfg_err      <= err_nxt;
            cfg_err_idx  <= err_idx_nxt;
`ifdef SYN_WM8731_CFG_RETRY_EN
            retry_cnt    <= retry_nxt;
`endif
        end
    end

    // 'issued' marks the single outstanding LB access of the current state.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        poll_nxt    = poll_cnt;
        gap_nxt     = gap_cnt;
        issued_nxt  = issued;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        addr_nxt    = i2cm_addr;
        wdata_nxt   = i2cm_wr_data;
        done_nxt    = 1'b0;
        err_nxt     = cfg_err;
        err_idx_nxt = cfg_err_idx;
`ifdef SYN_WM8731_CFG_RETRY_EN
        retry_nxt   = retry_cnt;
`endif
        case (state)
            IDLE_S: begin
                if (cfg_start) begin
                    state_nxt  = WR_ADDR_S;
                    err_nxt    = 1'b0;
                    idx_nxt    = '0;
                    poll_nxt   = '0;
                    issued_nxt = 1'b0;
`ifdef SYN_WM8731_CFG_RETRY_EN
                    retry_nxt  = '0;
`endif
                end
            end
            WR_ADDR_S: begin
                if (!issued) begin
                    wr_en_nxt  = 1'b1;
                    addr_nxt   = P_LB_ADDR_W'(ACORTEX_I2CM_ADDR_REG_ADDR);
                    wdata_nxt  = P_LB_DATA_W'(P_I2C_DEV_ADDR);
                    issued_nxt = 1'b1;
                end else if (i2cm_wr_valid) begin
                    issued_nxt = 1'b0;
                    state_nxt  = WR_DATA_S;
                end
            end
            WR_DATA_S: begin
                if (!issued) begin
                    wr_en_nxt  = 1'b1;
                    addr_nxt   = P_LB_ADDR_W'(ACORTEX_I2CM_DATA_REG_ADDR);
                    wdata_nxt  = P_LB_DATA_W'(rom_bits);
                    issued_nxt = 1'b1;
                end else if (i2cm_wr_valid) begin
                    issued_nxt = 1'b0;
                    state_nxt  = TRIG_S;
                end
            end
            TRIG_S: begin
                if (!issued) begin
                    wr_en_nxt  = 1'b1;
                    addr_nxt   = P_LB_ADDR_W'(ACORTEX_I2CM_STATUS_REG_ADDR);
                    wdata_nxt  = '0;
                    issued_nxt = 1'b1;
                end else if (i2cm_wr_valid) begin
                    issued_nxt = 1'b0;
                    gap_nxt    = GAP_W'(P_POLL_GAP - 1);
                    state_nxt  = GAP_S;
                end
            end
            GAP_S: begin
                if (gap_cnt == '0) state_nxt = POLL_S;
                else               gap_nxt   = gap_cnt - GAP_W'(1);
            end
            POLL_S: begin
                if (!issued) begin
                    rd_en_nxt  = 1'b1;
                    addr_nxt   = P_LB_ADDR_W'(ACORTEX_I2CM_STATUS_REG_ADDR);
                    issued_nxt = 1'b1;
                end else if (i2cm_rd_valid) begin
                    issued_nxt = 1'b0;
                    if (i2cm_rd_data[0]) begin
                        if (poll_cnt != '1) poll_nxt = poll_cnt + POLL_W'(1);
                        if (poll_cnt >= POLL_W'(P_MAX_POLLS - 1)) begin
                            state_nxt = ERR_S;
                        end else begin
                            gap_nxt   = GAP_W'(P_POLL_GAP - 1);
                            state_nxt = GAP_S;
                        end
                    end else if (i2cm_rd_data[1]) begin
`ifdef SYN_WM8731_CFG_RETRY_EN
                        if (retry_cnt < 2'(P_MAX_RETRY)) begin
                            retry_nxt = retry_cnt + 2'd1;
                            poll_nxt  = '0;
                            state_nxt = WR_DATA_S;
                        end else begin
                            state_nxt = ERR_S;
                        end
`else
                        state_nxt = ERR_S;
`endif
                    end else begin
                        state_nxt = NEXT_S;
                    end
                end
            end
            NEXT_S: begin
                if (idx == 4'(P_NUM_CMDS - 1)) begin
                    state_nxt = DONE_S;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = idx + 4'd1;
                    poll_nxt  = '0;
`ifdef SYN_WM8731_CFG_RETRY_EN
                    retry_nxt = '0;
`endif
                    state_nxt = WR_DATA_S;
                end
            end
            DONE_S: state_nxt = IDLE_S;
            ERR_S: begin
                err_nxt     = 1'b1;
                err_idx_nxt = idx;
                state_nxt   = IDLE_S;
            end
            default: state_nxt = IDLE_S;
        endcase
    end

endmodule

// File: tb/tb_syn_wm8731_cfg_seq.sv
// Self-checking bench for syn_wm8731_cfg_seq with a behavioural I2C master
// on the local bus; table-driven scenarios plus hand-written corner cases.
module tb_syn_wm8731_cfg_seq;
    import syn_acortex_reg_map::*;

    localparam int TB_GAP = 2;
`ifdef SYN_WM8731_CFG_RETRY_EN
    localparam int NR = 3;
`else
    localparam int NR = 0;
`endif

    logic        clk_ir     = 1'b0;
    logic        rst_sync_l = 1'b0;
    logic        cfg_start  = 1'b0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [3:0]  cfg_err_idx;
    logic        i2cm_wr_en, i2cm_rd_en;
    logic [7:0]  i2cm_addr;
    logic [15:0] i2cm_wr_data;
    logic        i2cm_wr_valid = 1'b0;
    logic        i2cm_rd_valid = 1'b0;
    logic [15:0] i2cm_rd_data  = '0;
`ifdef SYN_WM8731_CFG_RETRY_EN
    logic [1:0]  cfg_retry_cnt;
`endif

    always #5 clk_ir = ~clk_ir;

    syn_wm8731_cfg_seq #(.P_POLL_GAP(TB_GAP)) dut (
        .clk_ir        (clk_ir),
        .rst_sync_l    (rst_sync_l),
        .cfg_start     (cfg_start),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .cfg_err_idx   (cfg_err_idx),
`ifdef SYN_WM8731_CFG_RETRY_EN
        .cfg_retry_cnt (cfg_retry_cnt),
`endif
        .i2cm_wr_en    (i2cm_wr_en),
        .i2cm_rd_en    (i2cm_rd_en),
        .i2cm_addr     (i2cm_addr),
        .i2cm_wr_data  (i2cm_wr_data),
        .i2cm_wr_valid (i2cm_wr_valid),
        .i2cm_rd_valid (i2cm_rd_valid),
        .i2cm_rd_data  (i2cm_rd_data)
    );

    logic [15:0] exp_words [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                    16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1000,
                                    16'h1201};

    // ---------------- I2C master model (responds one cycle after strobe)
    int          cyc = 0, last_trig = -1000;
    bit          wr_pend = 0, rd_pend = 0;
    logic [15:0] resp_pend = '0, cur_data = '0;
    logic [15:0] data_log [$];
    int          addr_writes = 0, done_cnt = 0, poll_total = 0, nacks_given = 0, polls_left = 0;
    int          viol_overlap = 0, viol_gap = 0, viol_proto = 0, viol_addr = 0;
    int          busy_polls = 3, nack_limit_abs = 0;
    bit          busy_forever = 0;
    logic [15:0] nack_word = 16'hFFFF;

    always @(negedge clk_ir) begin
        cyc++;
        if (!rst_sync_l) begin
            wr_pend = 0; rd_pend = 0;
            i2cm_wr_valid = 1'b0; i2cm_rd_valid = 1'b0; i2cm_rd_data = '0;
        end else begin
            if ((i2cm_wr_en || i2cm_rd_en) && (wr_pend || rd_pend)) viol_proto++;
            if (i2cm_wr_en && i2cm_rd_en) viol_overlap++;
            i2cm_wr_valid = wr_pend;
            i2cm_rd_valid = rd_pend;
            i2cm_rd_data  = rd_pend ? resp_pend : 16'h0000;
            wr_pend = i2cm_wr_en;
            rd_pend = i2cm_rd_en;
            if (cfg_done) done_cnt++;
            if (i2cm_wr_en) begin
                if (i2cm_addr == ACORTEX_I2CM_ADDR_REG_ADDR) begin
                    addr_writes++;
                    if (i2cm_wr_data != 16'h0034) viol_proto++;
                end else if (i2cm_addr == ACORTEX_I2CM_DATA_REG_ADDR) begin
                    data_log.push_back(i2cm_wr_data);
                    cur_data = i2cm_wr_data;
                end else if (i2cm_addr == ACORTEX_I2CM_STATUS_REG_ADDR) begin
                    if (i2cm_wr_data != 16'h0000) viol_proto++;
                    polls_left = busy_polls;
                    last_trig  = cyc;
                end else begin
                    viol_addr++;
                end
            end
            if (i2cm_rd_en) begin
                if (i2cm_addr != ACORTEX_I2CM_STATUS_REG_ADDR) viol_addr++;
                if (cyc - last_trig <= 3 || cyc - last_trig < TB_GAP + 2) viol_gap++;
                if (busy_forever || polls_left > 0) begin
                    resp_pend = 16'h0001;
                    if (polls_left > 0) polls_left--;
                    poll_total++;
                end else if (cur_data == nack_word && nacks_given < nack_limit_abs) begin
                    resp_pend = 16'h0002;
                    nacks_given++;
                end else begin
                    resp_pend = 16'h0000;
                end
            end
        end
    end

    // ---------------- checking helpers
    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_ir);
        cfg_start = 1'b1;
        @(negedge clk_ir);
        cfg_start = 1'b0;
    endtask

    task automatic run_seq(input int budget, output bit timeout, output bit busy_at_done,
                           output bit done_next, output bit busy_next, output logic [1:0] rmax);
        timeout = 1; busy_at_done = 0; done_next = 1; busy_next = 1; rmax = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_ir);
`ifdef SYN_WM8731_CFG_RETRY_EN
            if (cfg_retry_cnt > rmax) rmax = cfg_retry_cnt;
`endif
            if (cfg_done) begin
                busy_at_done = cfg_busy;
                @(negedge clk_ir);
                done_next = cfg_done;
                busy_next = cfg_busy;
                timeout = 0;
                break;
            end
            if (cfg_err) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic check_seq(input string tag, input int d0, input int nack_e, input int att,
                             input bit stop_err, input int stop_idx);
        int k;
        int exp_n;
        int n;
        bit ok;
        k = d0; exp_n = 0; ok = 1;
        for (int e = 0; e < 11; e++) begin
            n = (e == nack_e) ? att : 1;
            for (int a = 0; a < n; a++) begin
                if (k >= data_log.size() || data_log[k] !== exp_words[e]) ok = 0;
                k++;
                exp_n++;
            end
            if (stop_err && e == stop_idx) break;
        end
        check({tag, "_words"}, 32'(ok), 32'd1);
        check({tag, "_count"}, 32'(data_log.size() - d0), 32'(exp_n));
    endtask

    typedef struct {
        int polls;
        int nack_e;
        int nack_lim;
        int att;
        bit exp_err;
        int exp_idx;
        int exp_done;
        int exp_rmax;
    } vec_t;

    vec_t vec [6];

    initial begin
        int d0, a0, dn0, p0;
        bit to, bad, dnx, bnx;
        logic [1:0] rmax;
        string tag;

        vec[0] = '{3, -1, 0,   1,      0, 0,  1, 0};
        vec[1] = '{0, -1, 0,   1,      0, 0,  1, 0};
        vec[2] = '{3,  4, 100, NR + 1, 1, 4,  0, NR};
        vec[3] = '{1,  0, 100, NR + 1, 1, 0,  0, NR};
        vec[4] = '{2, 10, 100, NR + 1, 1, 10, 0, NR};
`ifdef SYN_WM8731_CFG_RETRY_EN
        vec[5] = '{3,  2, 2,   3,      0, 0,  1, 2};
`else
        vec[5] = '{3,  2, 2,   1,      1, 2,  0, 0};
`endif

        // reset state
        repeat (3) @(negedge clk_ir);
        check("rst_busy",    32'(cfg_busy),     32'd0);
        check("rst_done",    32'(cfg_done),     32'd0);
        check("rst_err",     32'(cfg_err),      32'd0);
        check("rst_err_idx", 32'(cfg_err_idx),  32'd0);
        check("rst_wr_en",   32'(i2cm_wr_en),   32'd0);
        check("rst_rd_en",   32'(i2cm_rd_en),   32'd0);
        check("rst_addr",    32'(i2cm_addr),    32'd0);
        check("rst_wr_data", 32'(i2cm_wr_data), 32'd0);
        #1 rst_sync_l = 1'b1;
        repeat (2) @(negedge clk_ir);
        check("idle_busy", 32'(cfg_busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            tag = $sformatf("vec%0d", v);
            busy_polls     = vec[v].polls;
            nack_word      = (vec[v].nack_e >= 0) ? exp_words[vec[v].nack_e] : 16'hFFFF;
            nack_limit_abs = nacks_given + vec[v].nack_lim;
            d0 = data_log.size(); a0 = addr_writes; dn0 = done_cnt;
            pulse_start();
            check({tag, "_busy_rise"}, 32'(cfg_busy), 32'd1);
            run_seq(3000, to, bad, dnx, bnx, rmax);
            check({tag, "_timeout"}, 32'(to), 32'd0);
            repeat (30) @(negedge clk_ir);
            check({tag, "_err"}, 32'(cfg_err), 32'(vec[v].exp_err));
            if (vec[v].exp_err) check({tag, "_err_idx"}, 32'(cfg_err_idx), 32'(vec[v].exp_idx));
            check({tag, "_done_cnt"}, 32'(done_cnt - dn0), 32'(vec[v].exp_done));
            check({tag, "_addr_wr"}, 32'(addr_writes - a0), 32'd1);
            check({tag, "_busy_end"}, 32'(cfg_busy), 32'd0);
            if (vec[v].exp_done != 0) begin
                check({tag, "_busy_w_done"}, 32'(bad), 32'd1);
                check({tag, "_done_fall"},   32'(dnx), 32'd0);
                check({tag, "_busy_fall"},   32'(bnx), 32'd0);
            end
`ifdef SYN_WM8731_CFG_RETRY_EN
            check({tag, "_retry_max"}, 32'(rmax), 32'(vec[v].exp_rmax));
`endif
            check_seq(tag, d0, vec[v].nack_e, vec[v].att, vec[v].exp_err, vec[v].exp_idx);
        end

        // master stuck busy: timeout after the poll limit on entry 0
        busy_forever = 1; nack_word = 16'hFFFF;
        d0 = data_log.size(); p0 = poll_total; dn0 = done_cnt;
        pulse_start();
        run_seq(20000, to, bad, dnx, bnx, rmax);
        check("stuck_timeout", 32'(to), 32'd0);
        repeat (10) @(negedge clk_ir);
        busy_forever = 0;
        check("stuck_err",      32'(cfg_err),          32'd1);
        check("stuck_err_idx",  32'(cfg_err_idx),      32'd0);
        check("stuck_polls",    32'(poll_total - p0),  32'd1023);
        check("stuck_data_wr",  32'(data_log.size() - d0), 32'd1);
        check("stuck_no_done",  32'(done_cnt - dn0),   32'd0);

        // cfg_start while busy on entry 5 is ignored
        busy_polls = 3;
        d0 = data_log.size(); a0 = addr_writes; dn0 = done_cnt;
        pulse_start();
        to = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_ir);
            if (data_log.size() - d0 >= 6) begin to = 0; break; end
        end
        check("restart_reach5", 32'(to), 32'd0);
        pulse_start();
        run_seq(3000, to, bad, dnx, bnx, rmax);
        check("restart_timeout", 32'(to), 32'd0);
        repeat (10) @(negedge clk_ir);
        check("restart_done",   32'(done_cnt - dn0),    32'd1);
        check("restart_addr",   32'(addr_writes - a0),  32'd1);
        check("restart_err",    32'(cfg_err),           32'd0);
        check_seq("restart", d0, -1, 1, 0, 0);

        // async reset mid-poll, then a clean restart from entry 0
        d0 = data_log.size();
        pulse_start();
        to = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_ir);
            if (data_log.size() - d0 >= 3 && i2cm_rd_en) begin to = 0; break; end
        end
        check("arst_reach_poll", 32'(to), 32'd0);
        #2 rst_sync_l = 1'b0;
        #1;
        check("arst_busy",    32'(cfg_busy),     32'd0);
        check("arst_rd_en",   32'(i2cm_rd_en),   32'd0);
        check("arst_wr_en",   32'(i2cm_wr_en),   32'd0);
        check("arst_addr",    32'(i2cm_addr),    32'd0);
        check("arst_wr_data", 32'(i2cm_wr_data), 32'd0);
        check("arst_done",    32'(cfg_done),     32'd0);
        repeat (2) @(negedge clk_ir);
        #1 rst_sync_l = 1'b1;
        repeat (3) @(negedge clk_ir);
        d0 = data_log.size(); a0 = addr_writes; dn0 = done_cnt;
        pulse_start();
        run_seq(3000, to, bad, dnx, bnx, rmax);
        check("arst_rerun_timeout", 32'(to), 32'd0);
        repeat (10) @(negedge clk_ir);
        check("arst_rerun_done", 32'(done_cnt - dn0),   32'd1);
        check("arst_rerun_addr", 32'(addr_writes - a0), 32'd1);
        check_seq("arst_rerun", d0, -1, 1, 0, 0);

        // bus protocol monitors over the whole run
        check("no_wr_rd_overlap", 32'(viol_overlap), 32'd0);
        check("poll_gap",         32'(viol_gap),     32'd0);
        check("lb_protocol",      32'(viol_proto),   32'd0);
        check("lb_addresses",     32'(viol_addr),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
